// File: rtl/alu_share_if.sv
// Bundle between the two requesters, the shared ALU and the arbiter.
// slave: arbiter side. master: requesters plus the combinational ALU.
interface alu_share_if;
    logic       req0;
    logic       req1;
    logic       lock0;
    logic       lock1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [3:0] sel0;
    logic [3:0] sel1;
    logic       ack0;
    logic       ack1;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_y;
    logic [3:0] alu_flag;
    logic [7:0] y_out;
    logic [3:0] flag_out;
    logic       valid_out;
    logic       owner;

    modport slave (
        input  req0, req1, lock0, lock1, a0, b0, a1, b1, sel0, sel1, alu_y, alu_flag,
        output ack0, ack1, alu_a, alu_b, alu_sel, y_out, flag_out, valid_out, owner
    );

    modport master (
        output req0, req1, lock0, lock1, a0, b0, a1, b1, sel0, sel1, alu_y, alu_flag,
        input  ack0, ack1, alu_a, alu_b, alu_sel, y_out, flag_out, valid_out, owner
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter with bounded lock that shares one 8-bit ALU between the
// execute path (port 0) and the address/branch-compare path (port 1).
// Grant in cycle N, ALU operands registered at N+1, result captured at N+2.
module alu_share_arbiter #(
    parameter int unsigned LOCK_MAX = 4
) (
    input logic       clk,
    input logic       rst,
    alu_share_if.slave bus
);
    localparam logic [3:0] CntMax = 4'(LOCK_MAX);

    logic       ptr_q, ptr_d;
    logic       last_owner_q, last_owner_d;
    logic       lock_hold_q, lock_hold_d;
    logic [3:0] cnt_q, cnt_d;

    logic       gnt_valid;
    logic       gnt_id;

    logic       s1_valid_q, s1_owner_q;
    logic [7:0] alu_a_q, alu_b_q;
    logic [3:0] alu_sel_q;

    logic [7:0] y_q;
    logic [3:0] flag_q;
    logic       valid_q, owner_q;

    // Grant decision; acks are forced low while rst is high.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (!rst) begin
            unique case ({bus.req1, bus.req0})
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b0;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b1;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    // Once the lock budget is spent ptr points at the waiting port.
                    if (lock_hold_q && (cnt_q < CntMax)) begin
                        gnt_id = last_owner_q;
                    end else begin
                        gnt_id = ptr_q;
                    end
                end
                default: begin
                    gnt_valid = 1'b0;
                end
            endcase
        end
    end

    // Arbitration state next-state.
    always_comb begin
        ptr_d        = ptr_q;
        last_owner_d = last_owner_q;
        lock_hold_d  = lock_hold_q;
        cnt_d        = cnt_q;
        if (gnt_valid) begin
            ptr_d        = ~gnt_id;
            last_owner_d = gnt_id;
            lock_hold_d  = gnt_id ? bus.lock1 : bus.lock0;
            // cnt is nonzero exactly when the previous cycle produced a grant.
            if ((gnt_id == last_owner_q) && (cnt_q != 4'd0)) begin
                cnt_d = (cnt_q >= CntMax) ? CntMax : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
            end
        end else if (!bus.req0 && !bus.req1) begin
            cnt_d       = 4'd0;
            lock_hold_d = 1'b0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            last_owner_q <= 1'b0;
            lock_hold_q  <= 1'b0;
            cnt_q        <= 4'd0;
        end else begin
            ptr_q        <= ptr_d;
            last_owner_q <= last_owner_d;
            lock_hold_q  <= lock_hold_d;
            cnt_q        <= cnt_d;
        end
    end

    // Issue stage: register the granted port's operands into the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_owner_q <= 1'b0;
            alu_a_q    <= 8'd0;
            alu_b_q    <= 8'd0;
            alu_sel_q  <= 4'd0;
        end else begin
            s1_valid_q <= gnt_valid;
            if (gnt_valid) begin
                s1_owner_q <= gnt_id;
                alu_a_q    <= gnt_id ? bus.a1 : bus.a0;
                alu_b_q    <= gnt_id ? bus.b1 : bus.b0;
                alu_sel_q  <= gnt_id ? bus.sel1 : bus.sel0;
            end
        end
    end

    // Capture stage: latch ALU result and flags one cycle after issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= 8'd0;
            flag_q  <= 4'd0;
            valid_q <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                y_q     <= bus.alu_y;
                flag_q  <= bus.alu_flag;
                owner_q <= s1_owner_q;
            end
        end
    end

    assign bus.ack0      = gnt_valid & ~gnt_id;
    assign bus.ack1      = gnt_valid & gnt_id;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.y_out     = y_q;
    assign bus.flag_out  = flag_q;
    assign bus.valid_out = valid_q;
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: drivers push hand-computed results into
// a scoreboard at each ack; a monitor pops and compares on every valid_out.
module tb_alu_share_arbiter;
    localparam int unsigned LockMax = 4;

    typedef struct packed {
        logic        owner;
        logic [7:0]  y;
        logic [3:0]  f;
        logic [31:0] cyc;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc = 32'd0;
    int          n_cmp = 0;
    int          n_err = 0;
    sb_entry_t   sb_q[$];
    logic        grant_log[$];
    sb_entry_t   mon_e;

    alu_share_if bus ();

    alu_share_arbiter #(.LOCK_MAX(LockMax)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Combinational ALU model sitting on the shared ALU inputs.
    logic [8:0] alu_sum, alu_dif;
    logic [7:0] alu_res;
    logic       alu_c, alu_bw;
    assign alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign alu_dif = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
    always_comb begin
        alu_res = 8'd0;
        alu_c   = 1'b0;
        alu_bw  = 1'b0;
        case (bus.alu_sel)
            4'd0: begin alu_res = alu_sum[7:0]; alu_c = alu_sum[8]; end
            4'd1: begin alu_res = alu_dif[7:0]; alu_bw = alu_dif[8]; end
            4'd2: alu_res = bus.alu_a & bus.alu_b;
            4'd3: alu_res = bus.alu_a | bus.alu_b;
            default: alu_res = 8'd0;
        endcase
    end
    assign bus.alu_y    = alu_res;
    assign bus.alu_flag = {alu_res == 8'd0, alu_c, alu_bw, ~^alu_res};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                          input logic lk, input logic [7:0] ey, input logic [3:0] ef,
                          output int waited);
        sb_entry_t e;
        int t = 0;
        bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.sel0 = sel; bus.lock0 = lk;
        @(negedge clk);
        while (!bus.ack0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (!bus.ack0) begin
            check("ack0_timeout", 32'd0, 32'd1);
        end else begin
            e.owner = 1'b0; e.y = ey; e.f = ef; e.cyc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0; bus.lock0 = 1'b0;
    endtask

    task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                          input logic lk, input logic [7:0] ey, input logic [3:0] ef,
                          output int waited);
        sb_entry_t e;
        int t = 0;
        bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.sel1 = sel; bus.lock1 = lk;
        @(negedge clk);
        while (!bus.ack1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (!bus.ack1) begin
            check("ack1_timeout", 32'd0, 32'd1);
        end else begin
            e.owner = 1'b1; e.y = ey; e.f = ef; e.cyc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.req1 = 1'b0; bus.lock1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        idle(2);
        rst = 1'b0;
        grant_log.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack0"}, 32'(bus.ack0), 32'd0);
        check({tag, "_ack1"}, 32'(bus.ack1), 32'd0);
        check({tag, "_alu_a"}, 32'(bus.alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(bus.alu_b), 32'd0);
        check({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'd0);
        check({tag, "_y_out"}, 32'(bus.y_out), 32'd0);
        check({tag, "_flag_out"}, 32'(bus.flag_out), 32'd0);
        check({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
        check({tag, "_owner"}, 32'(bus.owner), 32'd0);
    endtask

    task automatic check_grants(input string name, input logic [15:0] exp, input int n);
        check({name, "_count"}, 32'(grant_log.size()), 32'(n));
        for (int i = 0; i < n && i < grant_log.size(); i++) begin
            check($sformatf("%s_grant%0d", name, i), 32'(grant_log[i]), 32'(exp[i]));
        end
    endtask

    // Grant log and mutual-exclusion of acks.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                check("ack_onehot", 32'(bus.ack0 & bus.ack1), 32'd0);
                grant_log.push_back(bus.ack1);
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.valid_out) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: got owner %0d y 0x%0h, want no result",
                             bus.owner, bus.y_out);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("owner", 32'(bus.owner), 32'(mon_e.owner));
                    check("y_out", 32'(bus.y_out), 32'(mon_e.y));
                    check("flag_out", 32'(bus.flag_out), 32'(mon_e.f));
                    check("latency", cyc, mon_e.cyc + 32'd2);
                end
            end
        end
    end

    initial begin
        int w, w0, w1, wsum;
        logic [31:0] c0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
        bus.a0 = 8'd0; bus.b0 = 8'd0; bus.a1 = 8'd0; bus.b1 = 8'd0;
        bus.sel0 = 4'd0; bus.sel1 = 4'd0;
        rst = 1'b1;
        idle(2);
        check_reset_values("por");
        rst = 1'b0;

        // Single-port operations.
        issue0(8'hF0, 8'h20, 4'd0, 1'b0, 8'h10, 4'b0100, w);
        check("first_ack0_wait", 32'(w), 32'd0);
        idle(3);
        issue1(8'h05, 8'h07, 4'd1, 1'b0, 8'hFE, 4'b0010, w);
        issue1(8'hAA, 8'h55, 4'd2, 1'b0, 8'h00, 4'b1001, w);
        idle(3);
        issue0(8'h55, 8'h0F, 4'd7, 1'b0, 8'h00, 4'b1001, w);
        idle(3);

        // Both ports requesting every cycle: strict alternation from port 0.
        do_reset();
        fork
            begin
                issue0(8'h01, 8'h02, 4'd0, 1'b0, 8'h03, 4'b0001, w0);
                issue0(8'h80, 8'h80, 4'd0, 1'b0, 8'h00, 4'b1101, w0);
                issue0(8'h0F, 8'hF0, 4'd3, 1'b0, 8'hFF, 4'b0001, w0);
                issue0(8'h10, 8'h01, 4'd1, 1'b0, 8'h0F, 4'b0001, w0);
            end
            begin
                issue1(8'h00, 8'h01, 4'd1, 1'b0, 8'hFF, 4'b0011, w1);
                issue1(8'hF0, 8'h3C, 4'd2, 1'b0, 8'h30, 4'b0001, w1);
                issue1(8'h7F, 8'h01, 4'd0, 1'b0, 8'h80, 4'b0000, w1);
                issue1(8'h00, 8'h00, 4'd3, 1'b0, 8'h00, 4'b1001, w1);
            end
        join
        idle(4);
        check_grants("alternate", 16'h00AA, 8);

        // Locked port 0 against a waiting port 1: forced handoff on the fifth grant.
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    issue0(8'h01, 8'h01, 4'd0, 1'b1, 8'h02, 4'b0000, w0);
                end
            end
            begin
                issue1(8'h0F, 8'h30, 4'd3, 1'b0, 8'h3F, 4'b0001, w1);
            end
        join
        idle(4);
        check_grants("lock", 16'h0010, 7);

        // Locked port 0 alone keeps the ALU every cycle.
        idle(2);
        c0 = cyc;
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            issue0(8'h03, 8'h01, 4'd1, 1'b1, 8'h02, 4'b0000, w);
            wsum += w;
        end
        check("solo_cycles", cyc - c0, 32'd8);
        check("solo_wait", 32'(wsum), 32'd0);
        idle(4);

        // Reset one cycle after ack0 discards the in-flight op.
        issue0(8'h33, 8'h11, 4'd1, 1'b0, 8'h22, 4'b0001, w);
        rst = 1'b1;
        sb_q.delete();
        bus.req0 = 1'b1; bus.a0 = 8'h11; bus.b0 = 8'h22; bus.sel0 = 4'd0;
        @(negedge clk);
        check("ack0_in_reset", 32'(bus.ack0), 32'd0);
        @(posedge clk); #1;
        check_reset_values("midrst");
        rst = 1'b0;
        issue0(8'h11, 8'h22, 4'd0, 1'b0, 8'h33, 4'b0001, w);
        check("post_reset_wait", 32'(w), 32'd0);

        // Drain the scoreboard.
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        idle(2);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
